// File: rtl/ndma_chan_sched_pkg.sv
// Shared types and constants for the NDMA channel scheduler: FSM state
// encoding, DMA configuration register map and small state helpers.
package ndma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARB    = 3'd1,
    ST_WR_SRC = 3'd2,
    ST_WR_DST = 3'd3,
    ST_WR_LEN = 3'd4,
    ST_WR_GO  = 3'd5,
    ST_BUSY   = 3'd6,
    ST_DONE   = 3'd7
  } ndma_state_e;

  // DMA configuration register map (byte offsets)
  localparam logic [31:0] CFG_OFF_SRC  = 32'h0000_0000;
  localparam logic [31:0] CFG_OFF_DST  = 32'h0000_0004;
  localparam logic [31:0] CFG_OFF_LEN  = 32'h0000_0008;
  localparam logic [31:0] CFG_OFF_GO   = 32'h0000_000C;
  localparam logic [31:0] CFG_GO_VALUE = 32'h0000_0001;

  // True for the four states that each perform one configuration write
  function automatic logic is_wr_state(ndma_state_e s);
    return (s == ST_WR_SRC) || (s == ST_WR_DST) ||
           (s == ST_WR_LEN) || (s == ST_WR_GO);
  endfunction

  // Register offset targeted by a write state
  function automatic logic [31:0] cfg_offset(ndma_state_e s);
    case (s)
      ST_WR_SRC: return CFG_OFF_SRC;
      ST_WR_DST: return CFG_OFF_DST;
      ST_WR_LEN: return CFG_OFF_LEN;
      ST_WR_GO:  return CFG_OFF_GO;
      default:   return 32'h0;
    endcase
  endfunction

  // Successor of a write state once its write has completed
  function automatic ndma_state_e next_wr_state(ndma_state_e s);
    case (s)
      ST_WR_SRC: return ST_WR_DST;
      ST_WR_DST: return ST_WR_LEN;
      ST_WR_LEN: return ST_WR_GO;
      ST_WR_GO:  return ST_BUSY;
      default:   return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ndma_chan_sched_if.sv
// Manager/subordinate bundle for the DMA configuration write port.
// req/we/addr/wdata travel manager->subordinate, gnt/rvalid come back.
interface ndma_chan_sched_if;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  gnt,
    input  rvalid
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output gnt,
    output rvalid
  );

endinterface

// File: rtl/ndma_rr_arb.sv
// Combinational round-robin arbiter: grants the lowest requesting index
// at or above ptr_i, wrapping to the lowest requesting index overall.
module ndma_rr_arb #(
  parameter int NumCh = 4
) (
  input  logic [NumCh-1:0]         req_i,
  input  logic [$clog2(NumCh)-1:0] ptr_i,
  output logic [NumCh-1:0]         gnt_o
);

  localparam int PtrW = $clog2(NumCh);

  logic [NumCh-1:0] mask;
  logic [NumCh-1:0] req_hi;
  logic [NumCh-1:0] gnt_hi;
  logic [NumCh-1:0] gnt_all;

  // Mask keeps only channels at or above the round-robin pointer
  for (genvar gi = 0; gi < NumCh; gi++) begin : g_mask
    assign mask[gi] = (PtrW'(gi) >= ptr_i);
  end

  assign req_hi = req_i & mask;

  // Isolate lowest set bit (x & -x) of the masked and unmasked vectors
  assign gnt_hi  = req_hi & (~req_hi + NumCh'(1));
  assign gnt_all = req_i  & (~req_i  + NumCh'(1));

  assign gnt_o = (|req_hi) ? gnt_hi : gnt_all;

endmodule

// File: rtl/ndma_chan_sched.sv
// NDMA channel scheduler: round-robin picks a requesting channel, programs
// the DMA through four configuration writes, then waits for a done edge
// or a watchdog timeout and reports the outcome to that channel.
module ndma_chan_sched
  import ndma_pkg::*;
#(
  parameter int NumCh         = 4,
  parameter int LenWidth      = 8,
  parameter int TimeoutCycles = 4096
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumCh-1:0]              ch_req_i,
  input  logic [NumCh-1:0][31:0]        ch_src_i,
  input  logic [NumCh-1:0][31:0]        ch_dst_i,
  input  logic [NumCh-1:0][LenWidth-1:0] ch_len_i,
  output logic [NumCh-1:0]              ch_gnt_o,
  output logic [NumCh-1:0]              ch_done_o,
  output logic [NumCh-1:0]              ch_err_o,
  ndma_chan_sched_if.master             cfg,
  input  logic                          dma_done_i,
  output logic                          busy_o
);

  localparam int PtrW = $clog2(NumCh);
  localparam int WdW  = $clog2(TimeoutCycles);

  ndma_state_e         state_reg, state_next;
  // 0: request phase (req high until gnt), 1: waiting for rvalid
  logic                wr_phase_reg, wr_phase_next;

  logic [PtrW-1:0]     rr_ptr_reg;
  logic [PtrW-1:0]     ch_idx_reg;
  logic [WdW-1:0]      wdog_reg;
  logic [31:0]         src_reg;
  logic [31:0]         dst_reg;
  logic [LenWidth-1:0] len_reg;
  logic                dma_done_reg;

  logic [NumCh-1:0]    arb_gnt;
  logic [PtrW-1:0]     win_idx;
  logic [31:0]         win_src;
  logic [31:0]         win_dst;
  logic [LenWidth-1:0] win_len;
  logic                done_edge;
  logic                wdog_expired;

  ndma_rr_arb #(
    .NumCh (NumCh)
  ) u_rr_arb (
    .req_i (ch_req_i),
    .ptr_i (rr_ptr_reg),
    .gnt_o (arb_gnt)
  );

  // Decode the one-hot winner into an index and its descriptor
  always_comb begin
    win_idx = '0;
    win_src = '0;
    win_dst = '0;
    win_len = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (arb_gnt[i]) begin
        win_idx = PtrW'(i);
        win_src = ch_src_i[i];
        win_dst = ch_dst_i[i];
        win_len = ch_len_i[i];
      end
    end
  end

  // Only a low->high transition counts; a level already high is ignored
  assign done_edge    = dma_done_i & ~dma_done_reg;
  assign wdog_expired = (wdog_reg == WdW'(TimeoutCycles - 1));

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= ST_IDLE;
      wr_phase_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wr_phase_reg <= wr_phase_next;
    end
  end

  // Descriptor capture, round-robin pointer, watchdog and done history
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_reg   <= '0;
      ch_idx_reg   <= '0;
      src_reg      <= '0;
      dst_reg      <= '0;
      len_reg      <= '0;
      wdog_reg     <= '0;
      dma_done_reg <= 1'b0;
    end else begin
      dma_done_reg <= dma_done_i;
      if (state_reg == ST_ARB && |arb_gnt) begin
        ch_idx_reg <= win_idx;
        src_reg    <= win_src;
        dst_reg    <= win_dst;
        len_reg    <= win_len;
        rr_ptr_reg <= (win_idx == PtrW'(NumCh - 1)) ? '0 : win_idx + PtrW'(1);
      end
      // Counts only while staying in BUSY, so it is zero on entry and
      // never wraps: it leaves BUSY as soon as it reaches the limit.
      if (state_reg == ST_BUSY && state_next == ST_BUSY) begin
        wdog_reg <= wdog_reg + WdW'(1);
      end else begin
        wdog_reg <= '0;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_next    = state_reg;
    wr_phase_next = wr_phase_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|ch_req_i) state_next = ST_ARB;
      end
      ST_ARB: begin
        if (|arb_gnt) begin
          state_next = (win_len == '0) ? ST_DONE : ST_WR_SRC;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WR_SRC, ST_WR_DST, ST_WR_LEN, ST_WR_GO: begin
        if (!wr_phase_reg) begin
          if (cfg.gnt) wr_phase_next = 1'b1;
        end else if (cfg.rvalid) begin
          wr_phase_next = 1'b0;
          state_next    = next_wr_state(state_reg);
        end
      end
      ST_BUSY: begin
        // Done has priority over a timeout in the same cycle
        if (done_edge) begin
          state_next = ST_DONE;
        end else if (wdog_expired) begin
          state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    cfg.req   = 1'b0;
    cfg.we    = 1'b0;
    cfg.addr  = '0;
    cfg.wdata = '0;
    ch_gnt_o  = '0;
    busy_o    = (state_reg != ST_IDLE);
    if (is_wr_state(state_reg)) begin
      // addr/wdata depend only on registered state, so they stay put
      // for the whole request phase regardless of gnt timing
      cfg.req  = ~wr_phase_reg;
      cfg.we   = ~wr_phase_reg;
      cfg.addr = cfg_offset(state_reg);
      case (state_reg)
        ST_WR_SRC: cfg.wdata = src_reg;
        ST_WR_DST: cfg.wdata = dst_reg;
        ST_WR_LEN: cfg.wdata = 32'(len_reg);
        default:   cfg.wdata = CFG_GO_VALUE;
      endcase
    end
    if (state_reg == ST_ARB) begin
      ch_gnt_o = arb_gnt;
    end
  end

  // Per-channel completion and timeout pulses for the captured channel
  for (genvar gi = 0; gi < NumCh; gi++) begin : g_ch_out
    assign ch_done_o[gi] = (state_reg == ST_DONE) && (ch_idx_reg == PtrW'(gi));
    assign ch_err_o[gi]  = (state_reg == ST_BUSY) && !done_edge && wdog_expired &&
                           (ch_idx_reg == PtrW'(gi));
  end

endmodule

// File: tb/tb_ndma_chan_sched.sv
// Self-checking bench for ndma_chan_sched: table of single transfers plus
// hand-written fairness, timeout and reset-in-BUSY sequences.
module tb_ndma_chan_sched;

  localparam int NumCh    = 4;
  localparam int LenWidth = 8;
  localparam int Tmo      = 16;

  localparam int Q_GNT  = 0;
  localparam int Q_WR   = 1;
  localparam int Q_DONE = 2;
  localparam int Q_ERR  = 3;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic [NumCh-1:0]               ch_req;
  logic [NumCh-1:0][31:0]         ch_src;
  logic [NumCh-1:0][31:0]         ch_dst;
  logic [NumCh-1:0][LenWidth-1:0] ch_len;
  logic [NumCh-1:0]               ch_gnt;
  logic [NumCh-1:0]               ch_done;
  logic [NumCh-1:0]               ch_err;
  logic                           dma_done;
  logic                           busy;

  ndma_chan_sched_if cfg_if ();

  ndma_chan_sched #(
    .NumCh         (NumCh),
    .LenWidth      (LenWidth),
    .TimeoutCycles (Tmo)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .ch_req_i   (ch_req),
    .ch_src_i   (ch_src),
    .ch_dst_i   (ch_dst),
    .ch_len_i   (ch_len),
    .ch_gnt_o   (ch_gnt),
    .ch_done_o  (ch_done),
    .ch_err_o   (ch_err),
    .cfg        (cfg_if),
    .dma_done_i (dma_done),
    .busy_o     (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- configuration port responder ----------------
  int          gnt_dly = 0;
  int          wait_cnt = 0;
  logic        pend_rv = 1'b0;
  logic        holding = 1'b0;
  logic [31:0] hold_addr, hold_data;
  int          stab_viol = 0;
  int          we_viol = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];

  initial begin
    cfg_if.gnt    = 1'b0;
    cfg_if.rvalid = 1'b0;
    forever begin
      @(negedge clk);
      cfg_if.gnt    = 1'b0;
      cfg_if.rvalid = 1'b0;
      if (!rst_ni) begin
        wait_cnt = 0;
        pend_rv  = 1'b0;
        holding  = 1'b0;
      end else begin
        if (pend_rv) begin
          cfg_if.rvalid = 1'b1;
          pend_rv       = 1'b0;
        end
        if (cfg_if.req) begin
          if (holding && (cfg_if.addr !== hold_addr || cfg_if.wdata !== hold_data))
            stab_viol++;
          hold_addr = cfg_if.addr;
          hold_data = cfg_if.wdata;
          holding   = 1'b1;
          if (wait_cnt >= gnt_dly) begin
            cfg_if.gnt = 1'b1;
            wait_cnt   = 0;
            pend_rv    = 1'b1;
            holding    = 1'b0;
            if (cfg_if.we !== 1'b1) we_viol++;
            wr_addr_q.push_back(cfg_if.addr);
            wr_data_q.push_back(cfg_if.wdata);
            wr_cyc_q.push_back(cyc);
          end else begin
            wait_cnt++;
          end
        end else begin
          holding = 1'b0;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  int gnt_ch_q[$], gnt_cyc_q[$];
  int done_ch_q[$], done_cyc_q[$];
  int err_ch_q[$], err_cyc_q[$];
  int onehot_viol = 0;
  int req_cycles  = 0;

  // Vectors are one-hot when valid, so $clog2 yields the set bit index
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if ($countones(ch_gnt) > 1 || $countones(ch_done) > 1 || $countones(ch_err) > 1)
        onehot_viol++;
      if (ch_gnt != '0) begin
        gnt_ch_q.push_back($clog2(ch_gnt));
        gnt_cyc_q.push_back(cyc);
      end
      if (ch_done != '0) begin
        done_ch_q.push_back($clog2(ch_done));
        done_cyc_q.push_back(cyc);
      end
      if (ch_err != '0) begin
        err_ch_q.push_back($clog2(ch_err));
        err_cyc_q.push_back(cyc);
      end
      if (cfg_if.req === 1'b1) req_cycles++;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    gnt_ch_q.delete();  gnt_cyc_q.delete();
    done_ch_q.delete(); done_cyc_q.delete();
    err_ch_q.delete();  err_cyc_q.delete();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    stab_viol = 0; we_viol = 0; onehot_viol = 0; req_cycles = 0;
  endtask

  function automatic int qsize(int which);
    case (which)
      Q_GNT:   return gnt_ch_q.size();
      Q_WR:    return wr_addr_q.size();
      Q_DONE:  return done_ch_q.size();
      default: return err_ch_q.size();
    endcase
  endfunction

  task automatic wait_for(int which, int n, int limit, string name);
    int k = 0;
    while (qsize(which) < n && k < limit) begin
      tick(1);
      k++;
    end
    chk({name, "_arrived"}, 64'(qsize(which) >= n), 64'd1);
  endtask

  task automatic check_idle_outputs(string name);
    chk({name, "_busy"},  64'(busy), 64'd0);
    chk({name, "_req"},   64'(cfg_if.req), 64'd0);
    chk({name, "_we"},    64'(cfg_if.we), 64'd0);
    chk({name, "_addr"},  64'(cfg_if.addr), 64'd0);
    chk({name, "_wdata"}, 64'(cfg_if.wdata), 64'd0);
    chk({name, "_gnt"},   64'(ch_gnt), 64'd0);
    chk({name, "_done"},  64'(ch_done), 64'd0);
    chk({name, "_err"},   64'(ch_err), 64'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  ch;
    logic [31:0] src;
    logic [31:0] dst;
    logic [7:0]  len;
    int          gnt_dly;
    int          exp_writes;
    logic [31:0] exp_len_word;
  } vec_t;

  vec_t vecs[4];
  logic [31:0] exp_addr[4];
  logic [31:0] exp_data[4];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    vecs[0] = '{ch: 2'd1, src: 32'h0000_1000, dst: 32'h0000_2000, len: 8'd16,
                gnt_dly: 0, exp_writes: 4, exp_len_word: 32'h0000_0010};
    vecs[1] = '{ch: 2'd3, src: 32'hDEAD_BEE0, dst: 32'h0000_4000, len: 8'hFF,
                gnt_dly: 5, exp_writes: 4, exp_len_word: 32'h0000_00FF};
    vecs[2] = '{ch: 2'd0, src: 32'h0000_0010, dst: 32'h8000_0020, len: 8'd1,
                gnt_dly: 2, exp_writes: 4, exp_len_word: 32'h0000_0001};
    vecs[3] = '{ch: 2'd2, src: 32'h1234_5678, dst: 32'h9ABC_DEF0, len: 8'd0,
                gnt_dly: 0, exp_writes: 0, exp_len_word: 32'h0000_0000};
    exp_addr[0] = 32'h0; exp_addr[1] = 32'h4; exp_addr[2] = 32'h8; exp_addr[3] = 32'hC;

    ch_req = '0; ch_src = '0; ch_dst = '0; ch_len = '0; dma_done = 1'b0;

    // ---- reset state ----
    tick(3);
    check_idle_outputs("reset");
    rst_ni = 1'b1;
    tick(1);
    chk("post_reset_no_cfg_req", 64'(cfg_if.req), 64'd0);
    chk("post_reset_idle", 64'(busy), 64'd0);

    // ---- fairness: all channels requesting continuously, zero length ----
    clear_logs();
    ch_len = '0;
    ch_req = '1;
    wait_for(Q_GNT, 5, 60, "fair_gnt");
    tick(1);
    ch_req = '0;
    tick(4);
    for (int i = 0; i < 5 && i < gnt_ch_q.size(); i++)
      chk($sformatf("fair_order_%0d", i), 64'(gnt_ch_q[i]), 64'(i % 4));
    chk("fair_done_count", 64'(done_ch_q.size()), 64'd5);
    chk("fair_onehot", 64'(onehot_viol), 64'd0);
    chk("fair_no_cfg", 64'(req_cycles), 64'd0);
    $display("xfer fairness grants=%0d dones=%0d", gnt_ch_q.size(), done_ch_q.size());

    // ---- table-driven single transfers ----
    for (int v = 0; v < 4; v++) begin
      clear_logs();
      gnt_dly = vecs[v].gnt_dly;
      exp_data[0] = vecs[v].src;
      exp_data[1] = vecs[v].dst;
      exp_data[2] = vecs[v].exp_len_word;
      exp_data[3] = 32'h1;
      ch_src[vecs[v].ch] = vecs[v].src;
      ch_dst[vecs[v].ch] = vecs[v].dst;
      ch_len[vecs[v].ch] = vecs[v].len;
      ch_req[vecs[v].ch] = 1'b1;
      wait_for(Q_GNT, 1, 20, $sformatf("v%0d_gnt", v));
      tick(1);
      ch_req = '0;
      if (vecs[v].exp_writes != 0) begin
        wait_for(Q_WR, 4, 200, $sformatf("v%0d_writes", v));
        tick(3);
        dma_done = 1'b1;
      end
      wait_for(Q_DONE, 1, 20, $sformatf("v%0d_done", v));
      tick(2);
      dma_done = 1'b0;
      tick(3);
      if (gnt_ch_q.size() > 0)
        chk($sformatf("v%0d_gnt_ch", v), 64'(gnt_ch_q[0]), 64'(vecs[v].ch));
      chk($sformatf("v%0d_gnt_count", v), 64'(gnt_ch_q.size()), 64'd1);
      chk($sformatf("v%0d_wr_count", v), 64'(wr_addr_q.size()), 64'(vecs[v].exp_writes));
      for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
        chk($sformatf("v%0d_wr%0d_addr", v, i), 64'(wr_addr_q[i]), 64'(exp_addr[i]));
        chk($sformatf("v%0d_wr%0d_data", v, i), 64'(wr_data_q[i]), 64'(exp_data[i]));
      end
      if (done_ch_q.size() > 0)
        chk($sformatf("v%0d_done_ch", v), 64'(done_ch_q[0]), 64'(vecs[v].ch));
      chk($sformatf("v%0d_done_count", v), 64'(done_ch_q.size()), 64'd1);
      chk($sformatf("v%0d_err_count", v), 64'(err_ch_q.size()), 64'd0);
      chk($sformatf("v%0d_stable", v), 64'(stab_viol), 64'd0);
      chk($sformatf("v%0d_we", v), 64'(we_viol), 64'd0);
      chk($sformatf("v%0d_req_cycles", v), 64'(req_cycles),
          64'(vecs[v].exp_writes * (vecs[v].gnt_dly + 1)));
      if (vecs[v].exp_writes == 0 && done_cyc_q.size() > 0 && gnt_cyc_q.size() > 0)
        chk($sformatf("v%0d_zero_len_latency", v), 64'(done_cyc_q[0] - gnt_cyc_q[0]), 64'd1);
      $display("xfer ch=%0d len=%0d writes=%0d dones=%0d", vecs[v].ch, vecs[v].len,
               wr_addr_q.size(), done_ch_q.size());
    end

    // ---- timeout: done level already high before WR_GO ----
    clear_logs();
    gnt_dly = 0;
    dma_done = 1'b1;
    ch_len[1] = 8'd4;
    ch_req[1] = 1'b1;
    wait_for(Q_GNT, 1, 20, "tmo_gnt");
    tick(1);
    ch_req = '0;
    wait_for(Q_WR, 4, 100, "tmo_writes");
    wait_for(Q_ERR, 1, 40, "tmo_err");
    tick(3);
    if (err_ch_q.size() > 0) begin
      chk("tmo_err_ch", 64'(err_ch_q[0]), 64'd1);
      // GO granted in cycle g, rvalid in g+1, BUSY g+2..g+17
      chk("tmo_err_cycle", 64'(err_cyc_q[0] - wr_cyc_q[3]), 64'd17);
    end
    chk("tmo_err_count", 64'(err_ch_q.size()), 64'd1);
    chk("tmo_no_done", 64'(done_ch_q.size()), 64'd0);
    chk("tmo_idle_after", 64'(busy), 64'd0);
    dma_done = 1'b0;
    tick(2);
    $display("xfer timeout ch=1 errs=%0d dones=%0d", err_ch_q.size(), done_ch_q.size());

    // ---- reset while BUSY ----
    clear_logs();
    ch_len[0] = 8'd3;
    ch_req[0] = 1'b1;
    wait_for(Q_GNT, 1, 20, "rst_gnt");
    tick(1);
    ch_req = '0;
    wait_for(Q_WR, 4, 100, "rst_writes");
    tick(4);
    chk("rst_busy_before", 64'(busy), 64'd1);
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    tick(2);
    check_idle_outputs("rst_hold");
    rst_ni = 1'b1;
    tick(1);
    chk("rst_release_no_req", 64'(cfg_if.req), 64'd0);
    clear_logs();
    ch_len[0] = 8'd0;
    ch_len[1] = 8'd0;
    ch_req = 4'b0011;
    wait_for(Q_GNT, 1, 20, "rst_next_gnt");
    if (gnt_ch_q.size() > 0)
      chk("rst_next_gnt_ch0", 64'(gnt_ch_q[0]), 64'd0);
    tick(1);
    ch_req[0] = 1'b0;
    wait_for(Q_GNT, 2, 20, "rst_second_gnt");
    if (gnt_ch_q.size() > 1)
      chk("rst_second_gnt_ch1", 64'(gnt_ch_q[1]), 64'd1);
    tick(1);
    ch_req = '0;
    tick(4);
    chk("rst_no_err", 64'(err_ch_q.size()), 64'd0);
    chk("rst_onehot", 64'(onehot_viol), 64'd0);
    $display("xfer reset_in_busy grants=%0d", gnt_ch_q.size());

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
